// File: rtl/raizing_rom_arbiter.sv
// raizing_rom_arbiter: shares one SDRAM bank read port between 68K, Z80 and PCM ROM clients, each with a one-word cache
module raizing_rom_arbiter #(
    parameter logic [21:0] Z80_OFFSET = 22'h040000,
    parameter logic [21:0] PCM_OFFSET = 22'h050000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ROM68K_CS,
    input  logic [18:0] ROM68K_ADDR,
    output logic        ROM68K_OK,
    output logic [15:0] ROM68K_DOUT,
    input  logic        ROMZ80_CS,
    input  logic [16:0] ROMZ80_ADDR,
    output logic        ROMZ80_OK,
    output logic [7:0]  ROMZ80_DOUT,
    input  logic        PCM_CS,
    input  logic [19:0] PCM_ADDR,
    output logic        PCM_OK,
    output logic [7:0]  PCM_DOUT,
    output logic [21:0] BA_ADDR,
    output logic        BA_RD,
    input  logic        BA_ACK,
    input  logic        BA_RDY,
    input  logic [15:0] DATA_READ
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_gnt;
    logic [1:0]  r_last;
    logic [2:0]  r_valid;
    logic [21:0] r_tag [0:2];
    logic [15:0] r_data [0:2];
    logic        r_ba_rd;
    logic [21:0] r_ba_addr;
    logic        r_ok68, r_okz, r_okp;
    logic [15:0] r_dout68;
    logic [7:0]  r_doutz, r_doutp;

    logic [21:0] w_wa [0:2];
    logic [2:0]  w_cs, w_hit, w_need;
    logic [1:0]  w_n1, w_n2, w_pick;

    assign w_wa[0] = {3'd0, ROM68K_ADDR};
    assign w_wa[1] = Z80_OFFSET + {6'd0, ROMZ80_ADDR[16:1]};
    assign w_wa[2] = PCM_OFFSET + {3'd0, PCM_ADDR[19:1]};
    assign w_cs    = {PCM_CS, ROMZ80_CS, ROM68K_CS};
    assign w_need  = w_cs & ~w_hit;

    // Cache lookup per client, then round-robin pick starting after the last granted client
    always_comb begin
        for (int i = 0; i < 3; i++)
            w_hit[i] = w_cs[i] & r_valid[i] & (r_tag[i] == w_wa[i]);
        w_n1   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_n2   = (w_n1 == 2'd2) ? 2'd0 : w_n1 + 2'd1;
        w_pick = w_need[w_n1] ? w_n1 : w_need[w_n2] ? w_n2 : r_last;
    end

    // Grant / request / wait sequencer; a fill always lands with the address latched at grant
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'd0;
            r_last    <= 2'd2;
            r_valid   <= 3'b000;
            r_ba_rd   <= 1'b0;
            r_ba_addr <= 22'd0;
        end else begin
            case (r_state)
                S_IDLE: if (|w_need) begin
                    r_gnt     <= w_pick;
                    r_ba_addr <= w_wa[w_pick];
                    r_ba_rd   <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_REQ: if (BA_ACK) begin
                    r_ba_rd <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (BA_RDY) begin
                    r_valid[r_gnt] <= 1'b1;
                    r_tag[r_gnt]   <= r_ba_addr;
                    r_data[r_gnt]  <= DATA_READ;
                    r_last         <= r_gnt;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered client outputs: OK follows hit, data updates only on a hit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ok68   <= 1'b0;
            r_okz    <= 1'b0;
            r_okp    <= 1'b0;
            r_dout68 <= 16'd0;
            r_doutz  <= 8'd0;
            r_doutp  <= 8'd0;
        end else begin
            r_ok68   <= w_hit[0];
            r_okz    <= w_hit[1];
            r_okp    <= w_hit[2];
            r_dout68 <= w_hit[0] ? r_data[0] : r_dout68;
            r_doutz  <= w_hit[1] ? (ROMZ80_ADDR[0] ? r_data[1][15:8] : r_data[1][7:0]) : r_doutz;
            r_doutp  <= w_hit[2] ? (PCM_ADDR[0] ? r_data[2][15:8] : r_data[2][7:0]) : r_doutp;
        end
    end

    assign ROM68K_OK   = r_ok68;
    assign ROM68K_DOUT = r_dout68;
    assign ROMZ80_OK   = r_okz;
    assign ROMZ80_DOUT = r_doutz;
    assign PCM_OK      = r_okp;
    assign PCM_DOUT    = r_doutp;
    assign BA_RD       = r_ba_rd;
    assign BA_ADDR     = r_ba_addr;
endmodule

// File: tb/tb_raizing_rom_arbiter.sv
// tb_raizing_rom_arbiter: scoreboard bench for the ROM arbiter with a simple SDRAM responder
module tb_raizing_rom_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ROM68K_CS = 1'b0;
    logic [18:0] ROM68K_ADDR = '0;
    logic        ROM68K_OK;
    logic [15:0] ROM68K_DOUT;
    logic        ROMZ80_CS = 1'b0;
    logic [16:0] ROMZ80_ADDR = '0;
    logic        ROMZ80_OK;
    logic [7:0]  ROMZ80_DOUT;
    logic        PCM_CS = 1'b0;
    logic [19:0] PCM_ADDR = '0;
    logic        PCM_OK;
    logic [7:0]  PCM_DOUT;
    logic [21:0] BA_ADDR;
    logic        BA_RD;
    logic        BA_ACK;
    logic        BA_RDY;
    logic [15:0] DATA_READ;

    int n_chk = 0;
    int n_pass = 0;
    logic [21:0] q_ba[$];
    logic [15:0] q68[$], qz[$], qp[$];
    bit  rsp_en = 1'b1;
    time rdy_time = 0;

    always #5 CLK = ~CLK;

    raizing_rom_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .ROM68K_CS(ROM68K_CS), .ROM68K_ADDR(ROM68K_ADDR), .ROM68K_OK(ROM68K_OK), .ROM68K_DOUT(ROM68K_DOUT),
        .ROMZ80_CS(ROMZ80_CS), .ROMZ80_ADDR(ROMZ80_ADDR), .ROMZ80_OK(ROMZ80_OK), .ROMZ80_DOUT(ROMZ80_DOUT),
        .PCM_CS(PCM_CS), .PCM_ADDR(PCM_ADDR), .PCM_OK(PCM_OK), .PCM_DOUT(PCM_DOUT),
        .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_ACK(BA_ACK), .BA_RDY(BA_RDY), .DATA_READ(DATA_READ)
    );

    function automatic logic [15:0] mem(input logic [21:0] a);
        case (a)
            22'h000010: mem = 16'hBEEF;
            22'h040001: mem = 16'h12AB;
            default:    mem = a[15:0] ^ 16'hA5C3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops expectations on every new SDRAM request and every new client data presentation
    logic        prev_rd = 1'b0, p68 = 1'b0, pz = 1'b0, pp = 1'b0;
    logic [19:0] a1_68 = '0, a2_68 = '0, a1_z = '0, a2_z = '0, a1_p = '0, a2_p = '0;
    always @(negedge CLK) begin
        if (!RESET) begin
            if (BA_RD && !prev_rd)
                chk("ba_addr", {10'd0, BA_ADDR}, q_ba.size() != 0 ? {10'd0, q_ba.pop_front()} : 32'hDEAD0000);
            if (ROM68K_OK && (!p68 || a1_68 != a2_68))
                chk("dout68", {16'd0, ROM68K_DOUT}, q68.size() != 0 ? {16'd0, q68.pop_front()} : 32'hDEAD0000);
            if (ROMZ80_OK && (!pz || a1_z != a2_z))
                chk("doutz80", {24'd0, ROMZ80_DOUT}, qz.size() != 0 ? {16'd0, qz.pop_front()} : 32'hDEAD0000);
            if (PCM_OK && (!pp || a1_p != a2_p))
                chk("doutpcm", {24'd0, PCM_DOUT}, qp.size() != 0 ? {16'd0, qp.pop_front()} : 32'hDEAD0000);
        end
        prev_rd <= BA_RD;
        p68 <= ROM68K_OK;
        pz  <= ROMZ80_OK;
        pp  <= PCM_OK;
        a2_68 <= a1_68; a1_68 <= {1'b0, ROM68K_ADDR};
        a2_z  <= a1_z;  a1_z  <= {3'd0, ROMZ80_ADDR};
        a2_p  <= a1_p;  a1_p  <= PCM_ADDR;
    end

    // SDRAM responder: ACK two cycles after a request, RDY two cycles after ACK
    initial begin
        logic [21:0] a;
        BA_ACK = 1'b0;
        BA_RDY = 1'b0;
        DATA_READ = 16'd0;
        forever begin
            @(negedge CLK);
            if (rsp_en && BA_RD && !RESET) begin
                a = BA_ADDR;
                repeat (2) begin
                    @(negedge CLK);
                    chk("rd_hold", {9'd0, BA_RD, BA_ADDR}, {9'd0, 1'b1, a});
                end
                BA_ACK = 1'b1;
                @(negedge CLK);
                BA_ACK = 1'b0;
                chk("rd_drop", {31'd0, BA_RD}, 32'd0);
                repeat (2) @(negedge CLK);
                BA_RDY = 1'b1;
                DATA_READ = mem(a);
                rdy_time = $time;
                @(negedge CLK);
                BA_RDY = 1'b0;
            end
        end
    end

    task automatic wait_ok(input int c, input string name);
        int n;
        logic v;
        n = 0;
        do begin
            @(negedge CLK);
            v = (c == 0) ? ROM68K_OK : (c == 1) ? ROMZ80_OK : PCM_OK;
            n++;
        end while (!v && n < 60);
        chk(name, {31'd0, v}, 32'd1);
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!BA_RD && n < 60);
        chk(name, {31'd0, BA_RD}, 32'd1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (3) step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_ok", {29'd0, ROM68K_OK, ROMZ80_OK, PCM_OK}, 32'd0);
        chk("rst_dout68", {16'd0, ROM68K_DOUT}, 32'd0);
        chk("rst_doutz", {24'd0, ROMZ80_DOUT}, 32'd0);
        chk("rst_doutp", {24'd0, PCM_DOUT}, 32'd0);
        chk("rst_ba_rd", {31'd0, BA_RD}, 32'd0);
        chk("rst_ba_addr", {10'd0, BA_ADDR}, 32'd0);

        // 68K miss
        q_ba.push_back(22'h000010);
        q68.push_back(16'hBEEF);
        step();
        ROM68K_CS = 1'b1;
        ROM68K_ADDR = 19'h00010;
        wait_ok(0, "m68_miss_ok");
        chk("m68_miss_lat", 32'($time - rdy_time), 32'd20);

        // Hit after CS drop
        step();
        ROM68K_CS = 1'b0;
        q68.push_back(16'hBEEF);
        step();
        ROM68K_CS = 1'b1;
        step();
        chk("m68_hit_ok", {31'd0, ROM68K_OK}, 32'd1);
        chk("m68_hit_no_rd", {31'd0, BA_RD}, 32'd0);
        step();
        ROM68K_CS = 1'b0;

        // Z80 byte select: miss on odd byte, then hit on even byte of the same word
        q_ba.push_back(22'h040001);
        qz.push_back(16'h0012);
        ROMZ80_CS = 1'b1;
        ROMZ80_ADDR = 17'h00003;
        wait_ok(1, "z80_miss_ok");
        chk("z80_miss_lat", 32'($time - rdy_time), 32'd20);
        qz.push_back(16'h00AB);
        step();
        ROMZ80_ADDR = 17'h00002;
        repeat (3) @(negedge CLK);
        chk("z80_hit_ok", {31'd0, ROMZ80_OK}, 32'd1);
        chk("z80_hit_no_rd", {31'd0, BA_RD}, 32'd0);

        // Round-robin from reset, two rounds
        step();
        RESET = 1'b1;
        ROMZ80_CS = 1'b0;
        step();
        RESET = 1'b0;
        q_ba.push_back(22'h000100); q_ba.push_back(22'h040008); q_ba.push_back(22'h050010);
        q68.push_back(16'hA4C3); qz.push_back(16'h00CB); qp.push_back(16'h00D3);
        ROM68K_CS = 1'b1; ROM68K_ADDR = 19'h00100;
        ROMZ80_CS = 1'b1; ROMZ80_ADDR = 17'h00010;
        PCM_CS = 1'b1;    PCM_ADDR = 20'h00020;
        wait_ok(0, "rr1_68_ok");
        wait_ok(1, "rr1_z80_ok");
        wait_ok(2, "rr1_pcm_ok");
        q_ba.push_back(22'h000200); q_ba.push_back(22'h040018); q_ba.push_back(22'h050020);
        q68.push_back(16'hA7C3); qz.push_back(16'h00A5); qp.push_back(16'h00A5);
        step();
        ROM68K_ADDR = 19'h00200;
        ROMZ80_ADDR = 17'h00031;
        PCM_ADDR = 20'h00041;
        repeat (2) @(negedge CLK);
        wait_ok(0, "rr2_68_ok");
        wait_ok(1, "rr2_z80_ok");
        wait_ok(2, "rr2_pcm_ok");

        // PCM address change while its read is in flight
        step();
        ROM68K_CS = 1'b0; ROMZ80_CS = 1'b0; PCM_CS = 1'b0;
        repeat (2) step();
        q_ba.push_back(22'h050080);
        PCM_CS = 1'b1;
        PCM_ADDR = 20'h00100;
        wait_rd("pcm_rd_seen");
        q_ba.push_back(22'h050100);
        qp.push_back(16'h00C3);
        step();
        PCM_ADDR = 20'h00200;
        wait_ok(2, "pcm_new_ok");
        step();
        PCM_CS = 1'b0;
        repeat (3) step();

        // Reset while waiting for RDY; a stale RDY afterwards must not fill the cache
        rsp_en = 1'b0;
        q_ba.push_back(22'h000300);
        ROM68K_CS = 1'b1;
        ROM68K_ADDR = 19'h00300;
        wait_rd("rst_rd_seen");
        BA_ACK = 1'b1;
        @(negedge CLK);
        BA_ACK = 1'b0;
        step();
        RESET = 1'b1;
        ROM68K_CS = 1'b0;
        step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rstw_ok", {29'd0, ROM68K_OK, ROMZ80_OK, PCM_OK}, 32'd0);
        chk("rstw_ba_rd", {31'd0, BA_RD}, 32'd0);
        BA_RDY = 1'b1;
        DATA_READ = 16'h1111;
        @(negedge CLK);
        BA_RDY = 1'b0;
        rsp_en = 1'b1;
        q_ba.push_back(22'h000300);
        q68.push_back(16'hA6C3);
        step();
        ROM68K_CS = 1'b1;
        step();
        chk("rstw_miss_ok", {31'd0, ROM68K_OK}, 32'd0);
        wait_ok(0, "rstw_refill_ok");
        step();
        ROM68K_CS = 1'b0;
        repeat (4) step();

        chk("q_ba_empty", q_ba.size(), 32'd0);
        chk("q68_empty", q68.size(), 32'd0);
        chk("qz_empty", qz.size(), 32'd0);
        chk("qp_empty", qp.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
